recip_quotient_mul: RTL



---
 rtl/recip_quotient_mul.sv | 115 +++++++++++
 1 files changed

// File: rtl/recip_quotient_mul.sv
// Radix-2 shift-add multiplier forming the divider's quotient mantissa from the
// dividend mantissa and the reciprocal estimate; truncates, saturates on product >= 2.0.
module recip_quotient_mul #(
    parameter int MANT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_WIDTH-1:0] dividend,
    input  logic [MANT_WIDTH-1:0] recip,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MANT_WIDTH-1:0] quotient,
    output logic                  ovf,
    output logic                  busy
);

    localparam int ACC_W = 2 * MANT_WIDTH;
    localparam int CNT_W = (MANT_WIDTH > 1) ? $clog2(MANT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t                state, state_next;
    logic [MANT_WIDTH-1:0] mcand, mcand_next;
    logic [MANT_WIDTH-1:0] mplier, mplier_next;
    logic [ACC_W-1:0]      acc, acc_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [MANT_WIDTH-1:0] quotient_next;
    logic                  ovf_next;
    logic                  out_valid_next;
    logic [ACC_W-1:0]      partial;
    logic [ACC_W-1:0]      acc_sum;

    // Handshake flags decode straight from the state register, so no input reaches them.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_next     = state;
        mcand_next     = mcand;
        mplier_next    = mplier;
        acc_next       = acc;
        cnt_next       = cnt;
        quotient_next  = quotient;
        ovf_next       = ovf;
        out_valid_next = out_valid;
        partial        = '0;
        if (mplier[cnt]) begin
            partial = {{MANT_WIDTH{1'b0}}, mcand} << cnt;
        end
        acc_sum = acc + partial;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    mcand_next  = dividend;
                    mplier_next = recip;
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = MUL;
                end
            end
            MUL: begin
                acc_next = acc_sum;
                cnt_next = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    // Product is Q2.(2*MANT_WIDTH-2); MSB set means >= 2.0.
                    cnt_next       = '0;
                    state_next     = DONE;
                    out_valid_next = 1'b1;
                    ovf_next       = acc_sum[ACC_W-1];
                    quotient_next  = acc_sum[ACC_W-1] ? '1 : acc_sum[ACC_W-2:MANT_WIDTH-1];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            mcand     <= mcand_next;
            mplier    <= mplier_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            quotient  <= quotient_next;
            ovf       <= ovf_next;
            out_valid <= out_valid_next;
        end
    end

endmodule
